// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter family.
// Holds the mode constants, the FSM state type and a one-hot to index helper.
package arbiter_pkg;

   localparam int ARB_MODE_RR    = 0;
   localparam int ARB_MODE_FIXED = 1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Callers zero-extend their vector to 32 bits and truncate the result to their index width.
   function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters (master side) and the arbiter (slave side).
interface rr_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [IDW-1:0]   grant_id;

   modport master (output req, input grant, grant_valid, grant_id);
   modport slave  (input req, output grant, grant_valid, grant_id);

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: rotate the eligible requests so the search starts
// after last_id (or at 0 in fixed mode), priority-encode, then rotate the winner back.
module rr_pick
   import arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int MODE  = ARB_MODE_RR,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDW-1:0]   last_id,
   output logic [N_REQ-1:0] winner,
   output logic             found
);

   localparam int SW = IDW + 1;

   logic [N_REQ-1:0]   eligible;
   logic [SW-1:0]      start;
   logic [2*N_REQ-1:0] rotated;
   logic [N_REQ-1:0]   first;
   logic [2*N_REQ-1:0] placed;
   logic               taken;

   assign eligible = req & ~mask;
   assign found    = |eligible;

   // NOTE: every variable written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      start   = '0;
      rotated = '0;
      first   = '0;
      placed  = '0;
      taken   = 1'b0;
      winner  = '0;

      if (MODE != ARB_MODE_FIXED) start = SW'(last_id) + SW'(1);

      // Start may equal N_REQ (after last_id = N_REQ-1); the doubled copy makes that a clean wrap.
      rotated = {eligible, eligible} >> start;

      for (int i = 0; i < N_REQ; i++) begin
         if (rotated[i] && !taken) begin
            first[i] = 1'b1;
            taken    = 1'b1;
         end
      end

      placed = {{N_REQ{1'b0}}, first} << start;
      winner = placed[N_REQ-1:0] | placed[2*N_REQ-1:N_REQ];
   end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with round-robin or fixed priority and an optional bound on how long
// a holder may keep the grant while others wait. Grant, valid and index are registered.
module rr_arbiter
   import arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MODE     = ARB_MODE_RR,
   parameter int MAX_HOLD = 0,
   parameter int IDW      = $clog2(N_REQ)
) (
   input  logic          clk,
   input  logic          res,
   rr_arbiter_if.slave   bus
);

   localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
   localparam logic [IDW-1:0] LAST_RST  = IDW'(N_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [HCW-1:0]   hold_q, hold_d;

   logic [N_REQ-1:0] pick_oh;
   logic             pick_found;
   logic [IDW-1:0]   pick_id;
   logic             holder_req;
   logic             others_req;
   logic             keep;

   // Masking the holder only matters for forced rotation; a released holder's bit is already 0.
   rr_pick #(
      .N_REQ (N_REQ),
      .MODE  (MODE),
      .IDW   (IDW)
   ) u_pick (
      .req     (bus.req),
      .mask    (grant_q),
      .last_id (last_q),
      .winner  (pick_oh),
      .found   (pick_found)
   );

   assign pick_id = IDW'(onehot_to_idx(32'(pick_oh)));

   always_comb begin
      holder_req = |(bus.req & grant_q);
      others_req = |(bus.req & ~grant_q);
      keep       = holder_req && ((MAX_HOLD == 0) || !others_req || (hold_q < HOLD_LAST));

      state_d = state_q;
      grant_d = grant_q;
      id_d    = id_q;
      last_d  = last_q;
      hold_d  = hold_q;

      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d = ARB_BUSY;
               grant_d = pick_oh;
               id_d    = pick_id;
               last_d  = pick_id;
               hold_d  = '0;
            end
         end
         ARB_BUSY: begin
            if (keep) begin
               if (hold_q < HOLD_LAST) hold_d = hold_q + HCW'(1);
            end else if (pick_found) begin
               grant_d = pick_oh;
               id_d    = pick_id;
               last_d  = pick_id;
               hold_d  = '0;
            end else begin
               state_d = ARB_IDLE;
               grant_d = '0;
               id_d    = '0;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
            id_d    = '0;
            hold_d  = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: every register, including last_id, is reset; there is no storage array to leave unreset.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         id_q    <= '0;
         last_q  <= LAST_RST;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = (state_q == ARB_BUSY);
   assign bus.grant_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: three 4-way instances (round-robin, fixed, round-robin
// with MAX_HOLD=3) driven from one vector table plus hand-written reset sequences.
module tb_rr_arbiter;
   import arbiter_pkg::*;

   typedef struct {
      int         sel;
      logic [3:0] req;
      logic [3:0] grant;
      logic       valid;
      logic [1:0] id;
   } vec_t;

   logic clk;
   logic res;
   int   checks;
   int   errors;
   vec_t vecs[$];

   rr_arbiter_if #(.N_REQ(4)) if_rr ();
   rr_arbiter_if #(.N_REQ(4)) if_fx ();
   rr_arbiter_if #(.N_REQ(4)) if_mh ();

   rr_arbiter #(.N_REQ(4), .MODE(ARB_MODE_RR), .MAX_HOLD(0)) dut_rr (
      .clk (clk), .res (res), .bus (if_rr.slave));
   rr_arbiter #(.N_REQ(4), .MODE(ARB_MODE_FIXED), .MAX_HOLD(0)) dut_fx (
      .clk (clk), .res (res), .bus (if_fx.slave));
   rr_arbiter #(.N_REQ(4), .MODE(ARB_MODE_RR), .MAX_HOLD(3)) dut_mh (
      .clk (clk), .res (res), .bus (if_mh.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int sel, input logic [3:0] req, input logic [3:0] grant,
                      input logic valid, input logic [1:0] id);
      vec_t v;
      v.sel = sel; v.req = req; v.grant = grant; v.valid = valid; v.id = id;
      vecs.push_back(v);
   endtask

   task automatic check_rr(input string tag, input logic [3:0] g, input logic v, input logic [1:0] id);
      check({tag, " grant"}, 32'(if_rr.grant), 32'(g));
      check({tag, " valid"}, 32'(if_rr.grant_valid), 32'(v));
      check({tag, " id"}, 32'(if_rr.grant_id), 32'(id));
   endtask

   initial begin
      logic [3:0] act_g;
      logic       act_v;
      logic [1:0] act_id;

      checks = 0;
      errors = 0;

      // Round-robin: each holder drops its request for one cycle; then holding, wrap.
      add(0, 4'b1110, 4'b0010, 1'b1, 2'd1);
      add(0, 4'b1101, 4'b0100, 1'b1, 2'd2);
      add(0, 4'b1011, 4'b1000, 1'b1, 2'd3);
      add(0, 4'b0111, 4'b0001, 1'b1, 2'd0);
      add(0, 4'b1111, 4'b0001, 1'b1, 2'd0);
      add(0, 4'b1111, 4'b0001, 1'b1, 2'd0);
      add(0, 4'b1110, 4'b0010, 1'b1, 2'd1);
      // Fixed priority: no preemption by a lower index, handover on release.
      add(1, 4'b1010, 4'b0010, 1'b1, 2'd1);
      add(1, 4'b1011, 4'b0010, 1'b1, 2'd1);
      add(1, 4'b1011, 4'b0010, 1'b1, 2'd1);
      add(1, 4'b1001, 4'b0001, 1'b1, 2'd0);
      add(1, 4'b1001, 4'b0001, 1'b1, 2'd0);
      add(1, 4'b1000, 4'b1000, 1'b1, 2'd3);
      // Forced rotation with MAX_HOLD=3: three cycles each.
      for (int k = 0; k < 10; k++) begin
         if ((k / 3) % 2 == 0) add(2, 4'b0011, 4'b0001, 1'b1, 2'd0);
         else                  add(2, 4'b0011, 4'b0010, 1'b1, 2'd1);
      end
      // Sole requester keeps the grant indefinitely (hold counter saturates).
      for (int k = 0; k < 6; k++) add(2, 4'b0001, 4'b0001, 1'b1, 2'd0);
      // A newcomer after saturation forces an immediate rotation.
      add(2, 4'b0011, 4'b0010, 1'b1, 2'd1);
      add(2, 4'b0011, 4'b0010, 1'b1, 2'd1);
      add(2, 4'b0011, 4'b0010, 1'b1, 2'd1);
      add(2, 4'b0011, 4'b0001, 1'b1, 2'd0);
      // Release to idle and regrant.
      add(0, 4'b0100, 4'b0100, 1'b1, 2'd2);
      add(0, 4'b0000, 4'b0000, 1'b0, 2'd0);
      add(0, 4'b1000, 4'b1000, 1'b1, 2'd3);
      add(0, 4'b0000, 4'b0000, 1'b0, 2'd0);

      // Reset with all requests high on the round-robin instance.
      res = 1'b1;
      if_rr.req = 4'b1111;
      if_fx.req = 4'b0000;
      if_mh.req = 4'b0000;
      @(posedge clk); #1;
      check_rr("reset", 4'b0000, 1'b0, 2'd0);
      res = 1'b0;
      @(posedge clk); #1;
      check_rr("first grant", 4'b0001, 1'b1, 2'd0);

      foreach (vecs[n]) begin
         if_rr.req = (vecs[n].sel == 0) ? vecs[n].req : 4'b0000;
         if_fx.req = (vecs[n].sel == 1) ? vecs[n].req : 4'b0000;
         if_mh.req = (vecs[n].sel == 2) ? vecs[n].req : 4'b0000;
         @(posedge clk); #1;
         case (vecs[n].sel)
            0:       begin act_g = if_rr.grant; act_v = if_rr.grant_valid; act_id = if_rr.grant_id; end
            1:       begin act_g = if_fx.grant; act_v = if_fx.grant_valid; act_id = if_fx.grant_id; end
            default: begin act_g = if_mh.grant; act_v = if_mh.grant_valid; act_id = if_mh.grant_id; end
         endcase
         check($sformatf("vec%0d grant", n), 32'(act_g), 32'(vecs[n].grant));
         check($sformatf("vec%0d valid", n), 32'(act_v), 32'(vecs[n].valid));
         check($sformatf("vec%0d id", n), 32'(act_id), 32'(vecs[n].id));
      end

      // Asynchronous reset while requester 2 holds the grant.
      if_rr.req = 4'b0100;
      if_fx.req = 4'b0000;
      if_mh.req = 4'b0000;
      @(posedge clk); #1;
      check_rr("pre-reset hold", 4'b0100, 1'b1, 2'd2);
      #3 res = 1'b1;
      #1;
      check_rr("async reset", 4'b0000, 1'b0, 2'd0);
      if_rr.req = 4'b1111;
      #2 res = 1'b0;
      @(posedge clk); #1;
      check_rr("post-reset grant", 4'b0001, 1'b1, 2'd0);
      @(posedge clk); #1;
      check_rr("post-reset keep", 4'b0001, 1'b1, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
